// File: rtl/alu_issue.sv
// alu_issue: decodes RV32IM OP/OP-IMM into ALU op_mode/func_op, holds operands across
// mul/div stalls and emits a writeback tag aligned with the ALU's registered result.
module alu_issue (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic [2:0]  o_op_mode,
  output logic [2:0]  o_func_op,
  output logic        o_fp_mode,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  input  logic        i_alu_stall,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic        o_wb_illegal
);
  logic        occ, fire, accept, ill_q;
  logic [4:0]  rd_q;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3, d_mode, d_func;
  logic        is_op, is_imm, alt, mext, legal;
  logic [31:0] d_a, d_b;
  logic        unused_rs1_field;
  assign unused_rs1_field = ^i_instr[19:15];
  assign opcode = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign f7     = i_instr[31:25];
  assign is_op  = opcode == 7'b0110011;
  assign is_imm = opcode == 7'b0010011;
  assign mext   = is_op && f7 == 7'b0000001;
  // alternate encoding (SUB/SRA/SRAI); for OP-IMM only the shift-right slot carries it
  assign alt    = f7 == 7'b0100000 && (is_op || f3 == 3'b101);
  assign legal  = is_op ? (mext ? (f3 == 3'b000 || f3 == 3'b100) :
                           f7 == 7'b0000000 ? f3 != 3'b011 :
                           alt && (f3 == 3'b000 || f3 == 3'b101))
                        : is_imm && (f3 == 3'b001 ? f7 == 7'b0000000 :
                                     f3 == 3'b101 ? (f7 == 7'b0000000 || alt) :
                                     f3 != 3'b011);
  always_comb begin
    d_mode = 3'd0;
    d_func = 3'b000;
    case (f3)
      3'b000: begin d_mode = 3'd4; d_func = {2'b00, alt}; end
      3'b001: d_mode = 3'd2;
      3'b010: d_mode = 3'd3;
      3'b100: begin d_mode = 3'd1; d_func = 3'b010; end
      3'b101: begin d_mode = 3'd2; d_func = alt ? 3'b011 : 3'b010; end
      3'b110: begin d_mode = 3'd1; d_func = 3'b001; end
      default: d_mode = 3'd1;
    endcase
    if (mext) begin
      d_mode = f3 == 3'b100 ? 3'd6 : 3'd5;
      d_func = 3'b000;
    end
    if (!legal) begin
      d_mode = 3'd0;
      d_func = 3'b000;
    end
  end
  assign d_a = legal ? i_rs1_data : 32'd0;
  assign d_b = !legal ? 32'd0 : is_op ? i_rs2_data :
               f3[1:0] == 2'b01 ? {27'd0, i_instr[24:20]} : {{20{i_instr[31]}}, i_instr[31:20]};
  assign fire      = occ && !i_alu_stall;
  assign o_ready   = !occ || !i_alu_stall;
  assign accept    = i_valid && o_ready;
  assign o_fp_mode = 1'b0;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ          <= 1'b0;
      o_op_mode    <= 3'd0;
      o_func_op    <= 3'd0;
      o_a          <= 32'd0;
      o_b          <= 32'd0;
      rd_q         <= 5'd0;
      ill_q        <= 1'b0;
      o_wb_valid   <= 1'b0;
      o_wb_rd      <= 5'd0;
      o_wb_illegal <= 1'b0;
    end else begin
      if (accept) begin
        occ       <= 1'b1;
        o_op_mode <= d_mode;
        o_func_op <= d_func;
        o_a       <= d_a;
        o_b       <= d_b;
        rd_q      <= i_instr[11:7];
        ill_q     <= !legal;
      end else if (fire) begin
        occ       <= 1'b0;
        o_op_mode <= 3'd0;
        o_func_op <= 3'd0;
        o_a       <= 32'd0;
        o_b       <= 32'd0;
      end
      o_wb_valid   <= fire;
      o_wb_rd      <= rd_q;
      o_wb_illegal <= ill_q;
    end
  end
endmodule
